// File: rtl/occupancy_pkg.sv
// occupancy_pkg: shared state type, fault bit positions and system-word field helpers
package occupancy_pkg;
   typedef enum logic {RUN, FAULT} state_t;
   localparam int FAULT_ORDER = 0;
   localparam int FAULT_RANGE = 1;
   // wide enough that count + N_EX full-scale entries, or minus N_EX full-scale exits, never wraps
   function automatic int sum_width(input int wordlen, input int n_ex);
      return wordlen + $clog2(n_ex + 1) + 2;
   endfunction
   // door 0 is least significant; within a door zone 0 is on top, and each zone is {entered, exited}
   function automatic int field_lsb(input int wordlen, input int n_zone, input int door, input int zone,
                                    input bit exited);
      return (door * n_zone + n_zone - 1 - zone) * 2 * wordlen + (exited ? 0 : wordlen);
   endfunction
endpackage

// File: rtl/occupancy_monitor_zone_accumulator.sv
// zone_accumulator: signed net head count for one zone plus out-of-range flags
module zone_accumulator
   import occupancy_pkg::*;
#(
   parameter int N_EX = 4,
   parameter int WORDLEN = 8,
   localparam int SW = sum_width(WORDLEN, N_EX)
) (
   input  logic [WORDLEN-1:0]      count,
   input  logic [N_EX*WORDLEN-1:0] entered,
   input  logic [N_EX*WORDLEN-1:0] exited,
   output logic signed [SW-1:0]    sum,
   output logic                    underflow,
   output logic                    overflow
);
   always_comb begin
      sum = SW'(count);
      for (int d = 0; d < N_EX; d++)
         sum = sum + SW'(entered[d*WORDLEN +: WORDLEN]) - SW'(exited[d*WORDLEN +: WORDLEN]);
   end
   assign underflow = sum[SW-1];
   assign overflow = !sum[SW-1] && |sum[SW-2:WORDLEN];
endmodule

// File: rtl/occupancy_monitor.sv
// occupancy_monitor: nested-zone head counter that commits consistent batches and halts on a sticky fault
module occupancy_monitor
   import occupancy_pkg::*;
#(
   parameter int N_EX = 4,
   parameter int N_ZONE = 2,
   parameter int WORDLEN = 8,
   localparam int FZW = N_ZONE > 1 ? $clog2(N_ZONE) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [2*WORDLEN*N_ZONE*N_EX-1:0] system,
   input  logic                            load,
   input  logic [N_ZONE*WORDLEN-1:0]       load_counts,
   input  logic                            clear_fault,
   output logic                            out_valid,
   output logic [N_ZONE*WORDLEN-1:0]       counts,
   output logic                            fault,
   output logic [1:0]                      fault_code,
   output logic [FZW-1:0]                  fault_zone
);
   localparam int SW = sum_width(WORDLEN, N_EX);
   state_t state, state_nx;
   logic accept, range_any, order_any, violation;
   logic [N_ZONE-1:0] range_err;
   logic [N_ZONE-2:0] order_err;
   logic signed [SW-1:0] sum [N_ZONE];
   logic [N_ZONE*WORDLEN-1:0] sum_counts;
   logic [FZW-1:0] range_zone, order_zone;
   logic [1:0] code;

   for (genvar z = 0; z < N_ZONE; z++) begin : g_zone
      logic [N_EX*WORDLEN-1:0] ent, ext;
      logic uf, of;
      for (genvar d = 0; d < N_EX; d++) begin : g_door
         assign ent[d*WORDLEN +: WORDLEN] = system[field_lsb(WORDLEN, N_ZONE, d, z, 1'b0) +: WORDLEN];
         assign ext[d*WORDLEN +: WORDLEN] = system[field_lsb(WORDLEN, N_ZONE, d, z, 1'b1) +: WORDLEN];
      end
      zone_accumulator #(.N_EX(N_EX), .WORDLEN(WORDLEN)) u_acc (
         .count    (counts[(N_ZONE-1-z)*WORDLEN +: WORDLEN]),
         .entered  (ent),
         .exited   (ext),
         .sum      (sum[z]),
         .underflow(uf),
         .overflow (of)
      );
      assign range_err[z] = uf | of;
      assign sum_counts[(N_ZONE-1-z)*WORDLEN +: WORDLEN] = sum[z][WORDLEN-1:0];
   end

   // nesting is only judged between zones whose own sums are representable
   for (genvar k = 0; k < N_ZONE-1; k++) begin : g_order
      assign order_err[k] = !range_err[k] && !range_err[k+1] && sum[k] < sum[k+1];
   end

   always_comb begin
      range_zone = '0;
      order_zone = '0;
      for (int i = N_ZONE-1; i >= 0; i--) range_zone = range_err[i] ? FZW'(i) : range_zone;
      for (int i = N_ZONE-2; i >= 0; i--) order_zone = order_err[i] ? FZW'(i) : order_zone;
   end

   always_comb begin
      code = '0;
      code[FAULT_RANGE] = range_any;
      code[FAULT_ORDER] = order_any;
   end

   assign range_any = |range_err;
   assign order_any = |order_err;
   assign violation = range_any | order_any;
   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= RUN;
      else state <= state_nx;

   always_comb
      state_nx = state == RUN ? (accept && violation ? FAULT : RUN) : (clear_fault ? RUN : FAULT);

   always_comb in_ready = state == RUN && !load;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         counts <= '0;
         fault <= 1'b0;
         fault_code <= '0;
         fault_zone <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= accept;
         if (load) counts <= load_counts;
         else if (accept && !violation) counts <= sum_counts;
         if (accept && violation) begin
            fault <= 1'b1;
            fault_code <= code;
            fault_zone <= range_any ? range_zone : order_zone;
         end else if (state == FAULT && clear_fault) begin
            fault <= 1'b0;
            fault_code <= '0;
            fault_zone <= '0;
         end
      end
endmodule

// File: tb/tb_occupancy_monitor.sv
// tb_occupancy_monitor: directed and random checks of occupancy_monitor against an integer model
module tb_occupancy_monitor;
   localparam int N_EX = 4, NZ = 2, W = 8;
   logic clk = 0, rst = 1, in_valid = 0, load = 0, clear_fault = 0;
   logic in_ready, out_valid, fault;
   logic [2*W*NZ*N_EX-1:0] system = '0;
   logic [NZ*W-1:0] load_counts = '0, counts;
   logic [1:0] fault_code;
   logic [0:0] fault_zone;
   int ent[N_EX][NZ], ext[N_EX][NZ], ld[NZ];
   int m_cnt[NZ], s[NZ];
   bit m_run = 1, m_fault = 0, m_ov = 0, r_any, o_any;
   int m_code = 0, m_zone = 0, rz, oz;
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   occupancy_monitor #(.N_EX(N_EX), .N_ZONE(NZ), .WORDLEN(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .system(system),
      .load(load), .load_counts(load_counts), .clear_fault(clear_fault), .out_valid(out_valid),
      .counts(counts), .fault(fault), .fault_code(fault_code), .fault_zone(fault_zone)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2*W*NZ*N_EX-1:0] pack_sys();
      logic [2*W*NZ*N_EX-1:0] v = '0;
      for (int d = 0; d < N_EX; d++)
         for (int z = 0; z < NZ; z++) begin
            v[(d*NZ+NZ-1-z)*2*W + W +: W] = W'(ent[d][z]);
            v[(d*NZ+NZ-1-z)*2*W +: W] = W'(ext[d][z]);
         end
      return v;
   endfunction

   function automatic logic [NZ*W-1:0] pack_cnt(input int c[NZ]);
      logic [NZ*W-1:0] v = '0;
      for (int z = 0; z < NZ; z++) v[(NZ-1-z)*W +: W] = W'(c[z]);
      return v;
   endfunction

   // model: head counts as plain integers, checked against the range and nesting rules
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int z = 0; z < NZ; z++) m_cnt[z] = 0;
         m_run = 1; m_fault = 0; m_code = 0; m_zone = 0; m_ov = 0;
      end else begin
         m_ov = in_valid && m_run && !load;
         if (m_ov) begin
            r_any = 0; o_any = 0; rz = 0; oz = 0;
            for (int z = 0; z < NZ; z++) begin
               s[z] = m_cnt[z];
               for (int d = 0; d < N_EX; d++) s[z] += ent[d][z] - ext[d][z];
            end
            for (int z = NZ-1; z >= 0; z--)
               if (s[z] < 0 || s[z] > 255) begin r_any = 1; rz = z; end
            for (int k = NZ-2; k >= 0; k--)
               if (s[k] >= 0 && s[k] <= 255 && s[k+1] >= 0 && s[k+1] <= 255 && s[k] < s[k+1]) begin
                  o_any = 1; oz = k;
               end
            if (r_any || o_any) begin
               m_fault = 1; m_code = {30'd0, r_any, o_any}; m_zone = r_any ? rz : oz; m_run = 0;
            end else m_cnt = s;
         end else if (!m_run && clear_fault) begin
            m_fault = 0; m_code = 0; m_zone = 0; m_run = 1;
         end
         if (load) m_cnt = ld;
      end
   end

   always @(negedge clk)
      if (!rst) begin
         chk("in_ready", in_ready, m_run && !load);
         chk("out_valid", out_valid, m_ov);
         chk("counts", counts, pack_cnt(m_cnt));
         chk("fault", fault, m_fault);
         chk("fault_code", fault_code, m_code);
         chk("fault_zone", fault_zone, m_zone);
      end

   task automatic clr();
      in_valid = 0; load = 0; clear_fault = 0;
      for (int d = 0; d < N_EX; d++)
         for (int z = 0; z < NZ; z++) begin ent[d][z] = 0; ext[d][z] = 0; end
   endtask

   task automatic tick();
      system = pack_sys();
      load_counts = pack_cnt(ld);
      @(posedge clk);
      #2;
   endtask

   task automatic unfault();
      clr(); clear_fault = 1; tick(); clr();
   endtask

   initial begin
      clr();
      ld[0] = 0; ld[1] = 0;
      repeat (2) @(posedge clk);
      #2 rst = 0;
      chk("rst_counts", counts, 0);
      chk("rst_fault", fault, 0);
      chk("rst_in_ready", in_ready, 1);
      // plain enter
      ent[0][0] = 5; ent[0][1] = 3; in_valid = 1; tick();
      chk("t2_out_valid", out_valid, 1);
      chk("t2_counts", counts, 16'h0503);
      chk("t2_fault", fault, 0);
      // inner zone overtakes outer
      clr(); ent[1][1] = 4; in_valid = 1; tick(); clr();
      chk("t3_fault", fault, 1);
      chk("t3_code", fault_code, 2'b01);
      chk("t3_zone", fault_zone, 0);
      chk("t3_counts", counts, 16'h0503);
      chk("t3_in_ready", in_ready, 0);
      unfault();
      chk("t3_cleared", fault, 0);
      chk("t3_ready_back", in_ready, 1);
      // underflow
      ext[2][0] = 6; in_valid = 1; tick(); clr();
      chk("t4_code", fault_code, 2'b10);
      chk("t4_zone", fault_zone, 0);
      chk("t4_counts", counts, 16'h0503);
      unfault();
      // overflow, then exact full scale
      load = 1; ld[0] = 250; ld[1] = 0; tick(); clr();
      chk("t5_load", counts, 16'hFA00);
      ent[0][0] = 3; ent[3][0] = 3; in_valid = 1; tick(); clr();
      chk("t5_ovf_code", fault_code, 2'b10);
      chk("t5_ovf_counts", counts, 16'hFA00);
      unfault();
      ent[0][0] = 2; ent[3][0] = 3; in_valid = 1; tick(); clr();
      chk("t5_full_counts", counts, 16'hFF00);
      chk("t5_full_fault", fault, 0);
      // load beats a valid batch
      load = 1; in_valid = 1; ent[0][0] = 1; ld[0] = 10; ld[1] = 5; tick(); clr();
      chk("t6_out_valid", out_valid, 0);
      chk("t6_counts", counts, 16'h0A05);
      ent[0][1] = 20; in_valid = 1; tick(); clr();
      chk("t6_order", fault_code, 2'b01);
      clear_fault = 1; in_valid = 1; ent[0][0] = 1; tick(); clr();
      chk("t6_clr_no_accept", out_valid, 0);
      chk("t6_clr_counts", counts, 16'h0A05);
      chk("t6_clr_fault", fault, 0);
      in_valid = 1; ent[0][0] = 1; tick(); clr();
      chk("t6_accept", counts, 16'h0B05);
      // equal nesting is legal, then inner underflow reports zone 1
      in_valid = 1; ent[2][1] = 6; tick(); clr();
      chk("eq_counts", counts, 16'h0B0B);
      chk("eq_fault", fault, 0);
      in_valid = 1; ext[1][1] = 12; tick(); clr();
      chk("z1_zone", fault_zone, 1);
      chk("z1_code", fault_code, 2'b10);
      unfault();
      // asynchronous reset mid-cycle with a batch pending
      in_valid = 1; ent[0][0] = 1; system = pack_sys();
      #1 rst = 1;
      #1;
      chk("arst_counts", counts, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_fault", fault, 0);
      clr();
      @(posedge clk); #2 rst = 0;
      @(posedge clk); #2;
      chk("arst_no_pulse", out_valid, 0);
      chk("arst_ready", in_ready, 1);
      // random traffic
      for (int n = 0; n < 3000; n++) begin
         clr();
         in_valid = $urandom_range(0, 9) < 7;
         load = $urandom_range(0, 19) == 0;
         clear_fault = $urandom_range(0, 4) == 0;
         ld[0] = $urandom_range(0, 3) == 0 ? 255 - int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
         ld[1] = $urandom_range(0, ld[0]);
         for (int d = 0; d < N_EX; d++)
            for (int z = 0; z < NZ; z++) begin
               ent[d][z] = $urandom_range(0, 39) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 2));
               ext[d][z] = $urandom_range(0, 39) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 2));
            end
         tick();
      end
      clr();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
